// File: rtl/ps2_key_receiver_if.sv
// PS/2 keyboard link bundle: the two raw keyboard lines plus the decoded key outputs.
// slave = receiver side, master = keyboard/stimulus side.
interface ps2_key_receiver_if;
    logic       ps2Clk;
    logic       ps2Data;
    logic [7:0] keycode;
    logic       newKeyStrobe;
    logic       extended;
    logic       parityErr;
    logic       frameErr;

    modport slave (
        input  ps2Clk, ps2Data,
        output keycode, newKeyStrobe, extended, parityErr, frameErr
    );

    modport master (
        output ps2Clk, ps2Data,
        input  keycode, newKeyStrobe, extended, parityErr, frameErr
    );
endinterface

// File: rtl/ps2_key_receiver.sv
// PS/2 keyboard receiver: synchronise and filter the keyboard lines, deframe bytes, track make/break/E0 codes.
// Optional macro PS2_PARITY_CHECK_EN enables odd-parity checking and the parityErr pulse.
module ps2_key_receiver #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic               clk100MHz,
    input  logic               reset,
    ps2_key_receiver_if.slave  bus
);
    localparam int FLT_W = $clog2(FILTER_LEN + 1);
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {ST_IDLE, ST_DATA, ST_PARITY, ST_STOP} state_e;

    logic             clk_meta_q, clk_sync_q, data_meta_q, data_sync_q;
    logic             flt_level_q;
    logic [FLT_W-1:0] flt_cnt_q;
    logic             flt_fire, fall_edge;

    state_e           state_q, state_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [7:0]       shift_q, shift_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             ext_pend_q, ext_pend_d, brk_pend_q, brk_pend_d;
    logic [7:0]       keycode_q, keycode_d;
    logic             extended_q, extended_d;
    logic             strobe_q, strobe_d, frame_err_q, frame_err_d;
    logic             byte_ok;
`ifdef PS2_PARITY_CHECK_EN
    logic             parity_q, parity_d, parity_err_q, parity_err_d;
`endif

    // Idle PS/2 lines float high, so the synchronisers and filter reset to 1.
    always_ff @(posedge clk100MHz or posedge reset) begin
        if (reset) begin
            clk_meta_q  <= 1'b1;
            clk_sync_q  <= 1'b1;
            data_meta_q <= 1'b1;
            data_sync_q <= 1'b1;
        end else begin
            // NOTE: non-blocking so each flop samples the previous stage's old value.
            clk_meta_q  <= bus.ps2Clk;
            clk_sync_q  <= clk_meta_q;
            data_meta_q <= bus.ps2Data;
            data_sync_q <= data_meta_q;
        end
    end

    // Any sample agreeing with the current level restarts the run, so a level change needs FILTER_LEN in a row.
    assign flt_fire  = (clk_sync_q != flt_level_q) && (flt_cnt_q == FLT_W'(FILTER_LEN - 1));
    assign fall_edge = flt_fire && flt_level_q;

    always_ff @(posedge clk100MHz or posedge reset) begin
        if (reset) begin
            flt_level_q <= 1'b1;
            flt_cnt_q   <= '0;
        end else if (clk_sync_q == flt_level_q) begin
            flt_cnt_q   <= '0;
        end else if (flt_fire) begin
            flt_level_q <= clk_sync_q;
            flt_cnt_q   <= '0;
        end else begin
            flt_cnt_q   <= flt_cnt_q + 1'b1;
        end
    end

    always_comb begin
        // NOTE: every next-state signal gets a default first so no path infers a latch.
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        tmo_d       = tmo_q;
        ext_pend_d  = ext_pend_q;
        brk_pend_d  = brk_pend_q;
        keycode_d   = keycode_q;
        extended_d  = extended_q;
        strobe_d    = 1'b0;
        frame_err_d = 1'b0;
        byte_ok     = 1'b0;
`ifdef PS2_PARITY_CHECK_EN
        parity_d     = parity_q;
        parity_err_d = 1'b0;
`endif

        if (state_q == ST_IDLE || fall_edge) begin
            tmo_d = '0;
        end else if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
            tmo_d       = '0;
            state_d     = ST_IDLE;
            frame_err_d = 1'b1;
        end else begin
            tmo_d = tmo_q + 1'b1;
        end

        if (fall_edge) begin
            unique case (state_q)
                ST_IDLE: if (!data_sync_q) begin
                    state_d   = ST_DATA;
                    bit_cnt_d = '0;
                end
                ST_DATA: begin
                    shift_d   = {data_sync_q, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == 3'd7) state_d = ST_PARITY;
                end
                ST_PARITY: begin
`ifdef PS2_PARITY_CHECK_EN
                    parity_d = data_sync_q;
`endif
                    state_d  = ST_STOP;
                end
                ST_STOP: begin
                    state_d = ST_IDLE;
                    if (!data_sync_q) begin
                        frame_err_d = 1'b1;
`ifdef PS2_PARITY_CHECK_EN
                    end else if (!(^{shift_q, parity_q})) begin
                        parity_err_d = 1'b1;
`endif
                    end else begin
                        byte_ok = 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        // A break only clears the output if it names the key currently shown.
        if (byte_ok) begin
            if (shift_q == 8'hE0) begin
                ext_pend_d = 1'b1;
            end else if (shift_q == 8'hF0) begin
                brk_pend_d = 1'b1;
            end else if (brk_pend_q) begin
                if (shift_q == keycode_q && ext_pend_q == extended_q) begin
                    keycode_d  = 8'h00;
                    extended_d = 1'b0;
                end
                brk_pend_d = 1'b0;
                ext_pend_d = 1'b0;
            end else begin
                keycode_d  = shift_q;
                extended_d = ext_pend_q;
                ext_pend_d = 1'b0;
                strobe_d   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk100MHz or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            tmo_q       <= '0;
            ext_pend_q  <= 1'b0;
            brk_pend_q  <= 1'b0;
            keycode_q   <= 8'h00;
            extended_q  <= 1'b0;
            strobe_q    <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            tmo_q       <= tmo_d;
            ext_pend_q  <= ext_pend_d;
            brk_pend_q  <= brk_pend_d;
            keycode_q   <= keycode_d;
            extended_q  <= extended_d;
            strobe_q    <= strobe_d;
            frame_err_q <= frame_err_d;
        end
    end

`ifdef PS2_PARITY_CHECK_EN
    always_ff @(posedge clk100MHz or posedge reset) begin
        if (reset) begin
            parity_q     <= 1'b0;
            parity_err_q <= 1'b0;
        end else begin
            parity_q     <= parity_d;
            parity_err_q <= parity_err_d;
        end
    end
    assign bus.parityErr = parity_err_q;
`else
    assign bus.parityErr = 1'b0;
`endif

    assign bus.keycode      = keycode_q;
    assign bus.extended     = extended_q;
    assign bus.newKeyStrobe = strobe_q;
    assign bus.frameErr     = frame_err_q;
endmodule

// File: doc/ps2_key_receiver.md
PS2_KEY_RECEIVER -- requirements
Module: ps2_key_receiver

Interface
REQ-001 SHALL have parameter: FILTER_LEN, 8, number of consecutive identical clk100MHz samples required before the ps2Clk level is accepted.
REQ-002 SHALL have parameter: TIMEOUT_CYCLES, 100000, clk100MHz cycles without a ps2Clk falling edge before a partial frame is abandoned (1 ms).
REQ-003 SHALL have port: clk100MHz  input  1  system clock, sole clock.
REQ-004 SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port: ps2Clk  input  1  keyboard clock, asynchronous to clk100MHz.
REQ-006 SHALL have port: ps2Data  input  1  keyboard data, asynchronous to clk100MHz.
REQ-007 SHALL have port: keycode  output  8  last make code received; 8'h00 when no key is held.
REQ-008 SHALL have port: newKeyStrobe  output  1  one-cycle pulse when keycode is updated by a make code.
REQ-009 SHALL have port: extended  output  1  keycode was prefixed by 8'hE0.
REQ-010 SHALL have port: parityErr  output  1  one-cycle pulse on a parity-failed frame.
REQ-011 SHALL have port: frameErr  output  1  one-cycle pulse on a bad stop bit or timeout.

Function
REQ-012 SHALL pass ps2Clk and ps2Data through 2-flop synchronizers before any use.
REQ-013 SHALL update the filtered ps2Clk level only after FILTER_LEN consecutive equal synchronized samples; a falling edge is a filtered 1->0 transition.
REQ-014 SHALL sample synchronized ps2Data on each filtered falling edge.
REQ-015 SHALL run FSM IDLE -> DATA -> PARITY -> STOP -> IDLE, one state advance per falling edge.
REQ-016 IDLE: sampled 0 (start) -> DATA with bit count 0; sampled 1 -> remain IDLE, no error.
REQ-017 DATA: shift in 8 bits LSB first; after the 8th bit -> PARITY.
REQ-018 PARITY: capture bit -> STOP.
REQ-019 STOP: sampled 1 -> byte accepted, go IDLE; sampled 0 -> frameErr pulse, byte discarded, go IDLE.
REQ-020 Outside IDLE, TIMEOUT_CYCLES cycles with no falling edge SHALL force IDLE, pulse frameErr, discard the partial byte; the counter clears on every falling edge and in IDLE.
REQ-021 Accepted 8'hE0 SHALL set extPending; no output change.
REQ-022 Accepted 8'hF0 SHALL set breakPending; no output change.
REQ-023 Accepted other byte with breakPending: if byte equals keycode and extPending equals extended, keycode <= 8'h00 and extended <= 0; else no change; clear both pending flags; no strobe.
REQ-024 Accepted other byte without breakPending: keycode <= byte, extended <= extPending, clear extPending, newKeyStrobe high exactly one cycle.
REQ-025 Outputs SHALL update on the clk100MHz edge following the cycle in which the stop-bit falling edge is detected; keycode/extended hold stable otherwise.
REQ-026 Repeated make codes (typematic) SHALL each produce a strobe even if keycode is unchanged.
REQ-027 newKeyStrobe, parityErr, frameErr SHALL never be high in the same cycle.

Reset
REQ-028 reset SHALL asynchronously force: FSM IDLE, bit count 0, shift register 0, extPending/breakPending 0, timeout counter 0, filter level 1, synchronizers 1.
REQ-029 reset SHALL force keycode 8'h00, extended 0, newKeyStrobe 0, parityErr 0, frameErr 0.
REQ-030 reset asserted mid-frame SHALL discard the frame; the first full frame after release SHALL decode normally.

Configuration
REQ-031 Macro PS2_PARITY_CHECK_EN defined: odd parity over 8 data bits plus parity bit checked in STOP; mismatch with valid stop -> parityErr pulse, byte discarded, pending flags unchanged.
REQ-032 Macro PS2_PARITY_CHECK_EN undefined: parity bit captured and ignored; parityErr tied 0.

Verification
REQ-033 Frame 8'h1B, correct parity -> keycode 8'h1B, extended 0, newKeyStrobe exactly one cycle.
REQ-034 Frames 8'h1B then 8'hF0, 8'h1B -> one strobe total; keycode 8'h00 after the third frame.
REQ-035 Frames 8'hE0, 8'h75 -> keycode 8'h75, extended 1, one strobe; then 8'hE0, 8'hF0, 8'h75 -> keycode 8'h00, extended 0.
REQ-036 With PS2_PARITY_CHECK_EN, frame 8'h2D with even parity -> parityErr one cycle, no strobe, keycode unchanged.
REQ-037 5 bits of a frame then ps2Clk idle high for TIMEOUT_CYCLES+10 -> frameErr one cycle; next frame 8'h4D -> keycode 8'h4D with strobe.
REQ-038 Glitch on ps2Clk low for FILTER_LEN-1 cycles -> no bit sampled; reset asserted after 4 bits of a frame -> all outputs reset values, next frame 8'h76 decodes with strobe.
